bcd_counter_n: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit.sv | 35 +++
 rtl/bcd_counter_n.sv | 118 +++++++++++
 tb/tb_bcd_counter_n.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family: digit limits, the
// counter FSM state type and the load clamp helper.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;

  // One-bit encoding; S_INIT is the reset state.
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } bcd_cnt_state_t;

  // Limit a raw nibble to a legal decimal digit: min(digit, 9).
  function automatic logic [3:0] bcd_clamp(input logic [3:0] digit);
    return (digit > BCD_MAX) ? BCD_MAX : digit;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit cell. Loads a clamped value or steps up/down by one
// with 9<->0 wrap. at_max/at_min feed the ripple-enable chain in the top.
module bcd_digit
  import bcd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       up,
  input  logic       ld,
  input  logic [3:0] ld_val,
  output logic [3:0] d,
  output logic       at_max,
  output logic       at_min
);

  // Digit register: load wins over step; a step past a limit wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d <= BCD_MIN;
    end else if (ld) begin
      d <= bcd_clamp(ld_val);
    end else if (step) begin
      if (up) begin
        d <= (d == BCD_MAX) ? BCD_MIN : d + 4'd1;
      end else begin
        d <= (d == BCD_MIN) ? BCD_MAX : d - 4'd1;
      end
    end
  end

  assign at_max = (d == BCD_MAX);
  assign at_min = (d == BCD_MIN);

endmodule

// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with clamped parallel load and
// registered carry/borrow/load_err pulses.
// Optional build macro BCD_CNT_SATURATE_EN: when defined, counting past
// all-9s or all-0s holds the value instead of wrapping; carry/borrow still
// pulse on every attempted step at the limit.
//
// Handshake: there is no valid/ready pair. en and load are level-sampled
// on every rising clk edge while the FSM is in S_RUN; the effect appears
// on q (and the pulse outputs) one cycle later. Inputs are ignored in S_INIT.
module bcd_counter_n
  import bcd_pkg::*;
#(
  parameter  int NUM_DIGITS = 3,
  localparam int W          = 4 * NUM_DIGITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         carry,
  output logic         borrow,
  output logic         load_err,
  output logic         busy_init
);

  bcd_cnt_state_t state, state_next;

  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_min;
  logic [NUM_DIGITS:0]   lower_max;   // bit i: all digits below i are 9
  logic [NUM_DIGITS:0]   lower_min;   // bit i: all digits below i are 0
  logic                  run;
  logic                  cnt_go;      // a count step is requested this cycle
  logic                  sat_block;   // step suppressed at the range limit
  logic                  ld_bad;      // some load digit is above 9

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_INIT;
    end else begin
      state <= state_next;
    end
  end

  // Next state: init lasts exactly one clock after reset release.
  always_comb begin
    state_next = state;
    busy_init  = 1'b0;
    case (state)
      S_INIT: begin
        busy_init  = 1'b1;
        state_next = S_RUN;
      end
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  assign run    = (state == S_RUN);
  assign cnt_go = run && !load && en;

  // Ripple-enable chains and load validation.
  always_comb begin
    lower_max    = '0;
    lower_min    = '0;
    ld_bad       = 1'b0;
    lower_max[0] = 1'b1;
    lower_min[0] = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      lower_max[i+1] = lower_max[i] && at_max[i];
      lower_min[i+1] = lower_min[i] && at_min[i];
      if (load_val[4*i +: 4] > BCD_MAX) begin
        ld_bad = 1'b1;
      end
    end
  end

`ifdef BCD_CNT_SATURATE_EN
  assign sat_block = up ? lower_max[NUM_DIGITS] : lower_min[NUM_DIGITS];
`else
  assign sat_block = 1'b0;
`endif

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic step_i;
    assign step_i = cnt_go && !sat_block && (up ? lower_max[i] : lower_min[i]);

    bcd_digit u_digit (
      .clk    (clk),
      .rst    (rst),
      .step   (step_i),
      .up     (up),
      .ld     (run && load),
      .ld_val (load_val[4*i +: 4]),
      .d      (q[4*i +: 4]),
      .at_max (at_max[i]),
      .at_min (at_min[i])
    );
  end

  // Pulse registers: one cycle per qualifying step or clamped load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      carry    <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= cnt_go && up && lower_max[NUM_DIGITS];
      borrow   <= cnt_go && !up && lower_min[NUM_DIGITS];
      load_err <= run && load && ld_bad;
    end
  end

endmodule

// File: tb/tb_bcd_counter_n.sv
// Bench for bcd_counter_n: integer-valued reference model, per-cycle
// compare on the falling edge, directed scenarios with literal values,
// then randomized traffic including asynchronous resets.
module tb_bcd_counter_n;

  localparam int ND = 3;
  localparam int W  = 4 * ND;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         up = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic         carry, borrow, load_err, busy_init;

  int n_checks = 0;
  int n_errors = 0;

  // model state: plain integer count plus pulse flags
  int m_val  = 0;
  bit m_init = 1'b1;
  bit m_c    = 1'b0;
  bit m_b    = 1'b0;
  bit m_le   = 1'b0;
  bit cmp_on = 1'b1;

  bcd_counter_n #(.NUM_DIGITS(ND)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .up        (up),
    .load      (load),
    .load_val  (load_val),
    .q         (q),
    .carry     (carry),
    .borrow    (borrow),
    .load_err  (load_err),
    .busy_init (busy_init)
  );

  // clock
  always #5 clk = ~clk;

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r = '0;
    int t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] all9();
    logic [W-1:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // reference model: decimal value arithmetic modulo 10^ND
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_val = 0; m_init = 1'b1; m_c = 1'b0; m_b = 1'b0; m_le = 1'b0;
    end else if (m_init) begin
      m_init = 1'b0; m_c = 1'b0; m_b = 1'b0; m_le = 1'b0;
    end else begin
      m_c = 1'b0; m_b = 1'b0; m_le = 1'b0;
      if (load) begin
        m_val = 0;
        for (int i = 0; i < ND; i++) begin
          int d;
          d = int'(load_val[4*i +: 4]);
          if (d > 9) begin
            d = 9;
            m_le = 1'b1;
          end
          m_val = m_val + d * p10(i);
        end
      end else if (en) begin
        if (up) begin
          if (m_val == p10(ND) - 1) begin
            m_c = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
            m_val = 0;
`endif
          end else begin
            m_val = m_val + 1;
          end
        end else begin
          if (m_val == 0) begin
            m_b = 1'b1;
`ifndef BCD_CNT_SATURATE_EN
            m_val = p10(ND) - 1;
`endif
          end else begin
            m_val = m_val - 1;
          end
        end
      end
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("q_model", 32'(q), 32'(to_bcd(m_val)));
      chk("carry_model", 32'(carry), 32'(m_c));
      chk("borrow_model", 32'(borrow), 32'(m_b));
      chk("load_err_model", 32'(load_err), 32'(m_le));
      chk("busy_init_model", 32'(busy_init), 32'(m_init));
    end
  end

  // driver: apply inputs now (at a falling edge), return at the next one
  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lv);
    en = e; up = u; load = l; load_val = lv;
    @(negedge clk);
  endtask

  initial begin
    // reset with en high
    en = 1'b1; up = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_q", 32'(q), 32'h000);
    chk("reset_busy", 32'(busy_init), 32'd1);
    chk("reset_pulses", 32'({carry, borrow, load_err}), 32'd0);
    rst = 1'b1;
    #1;
    chk("init_busy", 32'(busy_init), 32'd1);
    @(negedge clk);
    chk("init_q_held", 32'(q), 32'h000);
    chk("init_busy_off", 32'(busy_init), 32'd0);
    @(negedge clk);
    chk("first_count", 32'(q), 32'h001);

    // up-wrap
    drive(1'b0, 1'b1, 1'b1, 12'h998);
    chk("load_998", 32'(q), 32'h998);
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("up_999", 32'(q), 32'h999);
    chk("no_carry_999", 32'(carry), 32'd0);
    drive(1'b1, 1'b1, 1'b0, '0);
`ifdef BCD_CNT_SATURATE_EN
    chk("sat_hold_999", 32'(q), 32'h999);
`else
    chk("wrap_000", 32'(q), 32'h000);
`endif
    chk("carry_pulse", 32'(carry), 32'd1);
`ifdef BCD_CNT_SATURATE_EN
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("sat_hold_999_b", 32'(q), 32'h999);
    chk("sat_carry_b", 32'(carry), 32'd1);
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("sat_carry_c", 32'(carry), 32'd1);
`endif
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("carry_one_cycle", 32'(carry), 32'd0);

    // down-wrap
    drive(1'b0, 1'b0, 1'b1, 12'h001);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("down_000", 32'(q), 32'h000);
    chk("no_borrow_000", 32'(borrow), 32'd0);
    drive(1'b1, 1'b0, 1'b0, '0);
`ifdef BCD_CNT_SATURATE_EN
    chk("sat_hold_000", 32'(q), 32'h000);
`else
    chk("wrap_999", 32'(q), 32'h999);
`endif
    chk("borrow_pulse", 32'(borrow), 32'd1);
    chk("no_carry_down", 32'(carry), 32'd0);

    // invalid load, with en high too
    drive(1'b1, 1'b1, 1'b1, 12'hA5F);
    chk("clamp_959", 32'(q), 32'h959);
    chk("load_err_pulse", 32'(load_err), 32'd1);
    drive(1'b0, 1'b1, 1'b0, '0);
    chk("load_err_one_cycle", 32'(load_err), 32'd0);
    chk("hold_959", 32'(q), 32'h959);

    // direction flip, then async reset mid-cycle
    drive(1'b0, 1'b1, 1'b1, 12'h097);
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("up_098", 32'(q), 32'h098);
    drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 1'b0, '0);
    chk("up_100", 32'(q), 32'h100);
    drive(1'b1, 1'b0, 1'b0, '0);
    chk("flip_099", 32'(q), 32'h099);
    #2 rst = 1'b0;
    #1;
    chk("async_clear_q", 32'(q), 32'h000);
    chk("async_busy", 32'(busy_init), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [W-1:0] lv;
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0) lv = all9();
      else if (sel == 1) lv = '0;
      else lv = W'($urandom);
      en = ($urandom_range(0, 3) != 0);
      up = $urandom_range(0, 1);
      load = ($urandom_range(0, 15) == 0);
      load_val = lv;
      if ($urandom_range(0, 199) == 0) begin
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    en = 1'b0; load = 1'b0;
    @(negedge clk);
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
